// File: rtl/multi_edge_detect.sv
// multi_edge_detect
//   Per-channel synchroniser, debouncer and edge detector with mode-selected
//   events, sticky pending flags (write-one-to-clear) and an interrupt line.
//   Optional macro EDGE_COUNT_EN adds a saturating event counter per channel;
//   without it ev_count is tied to zero.
//
// Ports
//   clk       system clock
//   rst       synchronous reset, active-high
//   signal    raw asynchronous inputs, one bit per channel
//   mode      per-channel event select, bits [2i+1:2i]: 00 off, 01 rising,
//             10 falling, 11 both
//   clr       write-one-to-clear for pending (and counters)
//   level     debounced level per channel
//   pos_flag  one-cycle pulse on a debounced rising edge
//   neg_flag  one-cycle pulse on a debounced falling edge
//   evt       one-cycle event pulse: edge matching mode
//   pending   sticky event flags
//   irq       OR of pending
//   ev_count  per-channel event counters, CNT_W bits each
module multi_edge_detect #(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1,
  parameter int DB_W            = 16,
  parameter int CNT_W           = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       signal,
  input  logic [2*CHANNELS-1:0]     mode,
  input  logic [CHANNELS-1:0]       clr,
  output logic [CHANNELS-1:0]       level,
  output logic [CHANNELS-1:0]       pos_flag,
  output logic [CHANNELS-1:0]       neg_flag,
  output logic [CHANNELS-1:0]       evt,
  output logic [CHANNELS-1:0]       pending,
  output logic                      irq,
  output logic [CNT_W*CHANNELS-1:0] ev_count
);

  localparam int                PRIME_W    = 3;
  localparam logic [PRIME_W-1:0] PRIME_LOAD = PRIME_W'(SYNC_STAGES + 1);
  localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {PRIME, RUN} state_t;

  state_t               state_q, state_d;
  logic [PRIME_W-1:0]   prime_q, prime_d;

  logic [CHANNELS-1:0]  sync_p0 [SYNC_STAGES];
  logic [CHANNELS-1:0]  sync_s;
  logic [DB_W-1:0]      db_cnt_p1 [CHANNELS];

  // Control: PRIME lets the level follow the synchroniser until the chain
  // holds real input data, so an input idling high never looks like an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PRIME;
      prime_q <= PRIME_LOAD;
    end else begin
      state_q <= state_d;
      prime_q <= prime_d;
    end
  end

  always_comb begin
    state_d = state_q;
    prime_d = prime_q;
    case (state_q)
      PRIME: begin
        prime_d = prime_q - 1'b1;
        if (prime_q == PRIME_W'(1)) state_d = RUN;
      end
      RUN:     state_d = RUN;
      default: state_d = PRIME;
    endcase
  end

  // Stage p0: synchroniser chain
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_p0[k] <= '0;
    end else begin
      sync_p0[0] <= signal;
      for (int k = 1; k < SYNC_STAGES; k++) sync_p0[k] <= sync_p0[k-1];
    end
  end

  assign sync_s = sync_p0[SYNC_STAGES-1];

  // Stage p1: debounce and edge flags
  always_ff @(posedge clk) begin
    if (rst) begin
      level    <= '0;
      pos_flag <= '0;
      neg_flag <= '0;
      for (int c = 0; c < CHANNELS; c++) db_cnt_p1[c] <= '0;
    end else begin
      pos_flag <= '0;
      neg_flag <= '0;
      if (state_q == PRIME) begin
        level <= sync_s;
        for (int c = 0; c < CHANNELS; c++) db_cnt_p1[c] <= '0;
      end else begin
        for (int c = 0; c < CHANNELS; c++) begin
          if (sync_s[c] != level[c]) begin
            if (db_cnt_p1[c] == DB_LAST) begin
              level[c]     <= sync_s[c];
              db_cnt_p1[c] <= '0;
              pos_flag[c]  <= sync_s[c];
              neg_flag[c]  <= ~sync_s[c];
            end else begin
              db_cnt_p1[c] <= db_cnt_p1[c] + 1'b1;
            end
          end else begin
            // the run of differing samples broke: discard it
            db_cnt_p1[c] <= '0;
          end
        end
      end
    end
  end

  always_comb begin
    evt = '0;
    for (int c = 0; c < CHANNELS; c++)
      evt[c] = (pos_flag[c] & mode[2*c]) | (neg_flag[c] & mode[2*c+1]);
  end

  // Stage p2: sticky pending; a same-cycle event beats the clear
  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= (pending & ~clr) | evt;
  end

  assign irq = |pending;

`ifdef EDGE_COUNT_EN
  logic [CNT_W-1:0] cnt_p2 [CHANNELS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) cnt_p2[c] <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (clr[c])
          cnt_p2[c] <= CNT_W'(evt[c]);
        else if (evt[c] && (cnt_p2[c] != {CNT_W{1'b1}}))
          cnt_p2[c] <= cnt_p2[c] + 1'b1;
      end
    end
  end

  always_comb begin
    ev_count = '0;
    for (int c = 0; c < CHANNELS; c++) ev_count[CNT_W*c +: CNT_W] = cnt_p2[c];
  end
`else
  assign ev_count = '0;
`endif

endmodule
